tick_to_level: RTL and testbench

- Converts single-cycle ticks (such as edge-detector output) back into level pulses.
- Each accepted tick produces a registered high level lasting a programmable number of cycles.
- A guaranteed low gap follows each high level before the next one.
- Ticks that arrive while a pulse is in progress are either queued or used to retrigger (extend) the current pulse; the block drives level-sensitive downstream logic such as LEDs, enables and strobes.

---
 rtl/tick_shape_pkg.sv | 18 +
 rtl/sat_updown_cnt.sv | 33 +++
 rtl/tick_to_level.sv | 136 +++++++++++++
 tb/tb_tick_to_level.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_shape_pkg.sv
// Shared definitions for the tick-to-level pulse shaper: state encodings,
// retrigger mode constants and the FSM state type.
package tick_shape_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic RETRIG_QUEUE  = 1'b0;
    localparam logic RETRIG_EXTEND = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HIGH = ST_HIGH,
        S_GAP  = ST_GAP
    } state_e;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel; an increment
// attempted at full scale is dropped and flagged on o_ovf for that cycle.
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);

    logic [W-1:0] r_cnt;
    logic         w_full;
    logic         w_empty;

    assign w_full  = (r_cnt == {W{1'b1}});
    assign w_empty = (r_cnt == '0);
    assign o_ovf   = i_inc && !i_dec && w_full;
    assign o_cnt   = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && !w_empty) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/tick_to_level.sv
// Stretches single-cycle ticks into registered high levels of programmable
// length, separated by a guaranteed low gap; extra ticks are queued or retrigger.
module tick_to_level
    import tick_shape_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MIN_LOW = 2,
    parameter int PEND_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic              retrig_mode,
    input  logic              ovf_clr,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int GAP_W = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_LOW);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_next;
    logic [CNT_W-1:0]   w_hold_eff;
    logic               w_pend_chk;
    logic               w_pend_nz;
    logic               w_inc;
    logic               w_dec;
    logic               w_ovf_strobe;
    logic               r_level;
    logic               r_busy;
    logic               r_ovf;

    assign w_hold_eff = (hold_len == '0) ? CNT_W'(1) : hold_len;
    assign w_pend_nz  = (pend_cnt != '0);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_gap_next = r_gap;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        w_pend_chk = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick) begin
                    w_next     = S_HIGH;
                    w_cnt_next = w_hold_eff;
                end
            end
            S_HIGH: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (tick && (retrig_mode == RETRIG_EXTEND)) begin
                    w_cnt_next = w_hold_eff;
                end else begin
                    w_inc = tick;
                    if (r_cnt <= CNT_W'(1)) begin
                        if (MIN_LOW > 0) begin
                            w_next     = S_GAP;
                            w_gap_next = GAP_LOAD;
                        end else begin
                            w_pend_chk = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                w_inc      = tick;
                w_gap_next = r_gap - GAP_W'(1);
                if (r_gap <= GAP_W'(1)) begin
                    w_pend_chk = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Queued requests are served first; a same-cycle tick then takes its place.
        if (w_pend_chk) begin
            if (w_pend_nz || tick) begin
                w_next     = S_HIGH;
                w_cnt_next = w_hold_eff;
                w_dec      = w_pend_nz;
                w_inc      = tick && w_pend_nz;
            end else begin
                w_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_gap   <= w_gap_next;
            r_level <= (w_next == S_HIGH);
            r_busy  <= (w_next != S_IDLE);
            if (w_ovf_strobe) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    sat_updown_cnt #(
        .W(PEND_W)
    ) u_pend (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_cnt   (pend_cnt),
        .o_ovf   (w_ovf_strobe)
    );

    assign level    = r_level;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_tick_to_level.sv
// Directed bench for tick_to_level: three instances cover the default
// configuration, a 2-bit pending counter and a zero-gap configuration.
module tb_tick_to_level;

    logic       clk;
    logic       reset;
    logic [7:0] hold_len;
    logic       retrig_mode;
    logic       ovf_clr;
    logic       tick_a, tick_b, tick_c;

    logic       level_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       level_b, busy_b, ovf_b;
    logic [1:0] pend_b;
    logic       level_c, busy_c, ovf_c;
    logic [3:0] pend_c;

    int n_checks;
    int n_fail;

    tick_to_level #(.CNT_W(8), .MIN_LOW(2), .PEND_W(4)) u_a (
        .clk(clk), .reset(reset), .tick(tick_a), .hold_len(hold_len),
        .retrig_mode(retrig_mode), .ovf_clr(ovf_clr),
        .level(level_a), .busy(busy_a), .pend_cnt(pend_a), .overflow(ovf_a)
    );

    tick_to_level #(.CNT_W(8), .MIN_LOW(2), .PEND_W(2)) u_b (
        .clk(clk), .reset(reset), .tick(tick_b), .hold_len(hold_len),
        .retrig_mode(retrig_mode), .ovf_clr(ovf_clr),
        .level(level_b), .busy(busy_b), .pend_cnt(pend_b), .overflow(ovf_b)
    );

    tick_to_level #(.CNT_W(8), .MIN_LOW(0), .PEND_W(4)) u_c (
        .clk(clk), .reset(reset), .tick(tick_c), .hold_len(hold_len),
        .retrig_mode(retrig_mode), .ovf_clr(ovf_clr),
        .level(level_c), .busy(busy_c), .pend_cnt(pend_c), .overflow(ovf_c)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick_a = 0; tick_b = 0; tick_c = 0;
        hold_len = 8'd0; retrig_mode = 1'b0; ovf_clr = 1'b0;
        #3;
        n_checks++;
        if ({level_a, busy_a, pend_a, ovf_a} !== 7'd0) begin
            n_fail++; $display("FAIL reset_a: got %b expected 0", {level_a, busy_a, pend_a, ovf_a});
        end
        n_checks++;
        if ({level_b, busy_b, pend_b, ovf_b} !== 5'd0) begin
            n_fail++; $display("FAIL reset_b: got %b expected 0", {level_b, busy_b, pend_b, ovf_b});
        end
        n_checks++;
        if ({level_c, busy_c, pend_c, ovf_c} !== 7'd0) begin
            n_fail++; $display("FAIL reset_c: got %b expected 0", {level_c, busy_c, pend_c, ovf_c});
        end
        #9 reset = 1'b1;
        step();
        step();
    endtask

    task automatic test_single_tick();
        logic [15:0] exp_lv = 16'h000E;
        logic [15:0] exp_bz = 16'h003E;
        hold_len = 8'd3; retrig_mode = 1'b0;
        tick_a = 1'b1;
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_c0: got %b expected 0", busy_a);
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            tick_a = 1'b0;
            n_checks++;
            if (level_a !== exp_lv[c]) begin
                n_fail++; $display("FAIL single_level c%0d: got %b expected %b", c, level_a, exp_lv[c]);
            end
            n_checks++;
            if (busy_a !== exp_bz[c]) begin
                n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy_a, exp_bz[c]);
            end
        end
    endtask

    task automatic test_zero_hold();
        logic [15:0] exp_lv = 16'h0002;
        logic [15:0] exp_bz = 16'h000E;
        hold_len = 8'd0; retrig_mode = 1'b0;
        tick_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            tick_a = 1'b0;
            n_checks++;
            if (level_a !== exp_lv[c]) begin
                n_fail++; $display("FAIL zero_level c%0d: got %b expected %b", c, level_a, exp_lv[c]);
            end
            n_checks++;
            if (busy_a !== exp_bz[c]) begin
                n_fail++; $display("FAIL zero_busy c%0d: got %b expected %b", c, busy_a, exp_bz[c]);
            end
            n_checks++;
            if (pend_a !== 4'd0) begin
                n_fail++; $display("FAIL zero_pend c%0d: got %0d expected 0", c, pend_a);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [15:0] exp_lv = 16'h007E;
        logic [15:0] exp_bz = 16'h01FE;
        hold_len = 8'd4; retrig_mode = 1'b1;
        tick_a = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            tick_a = (c == 2);
            n_checks++;
            if (level_a !== exp_lv[c]) begin
                n_fail++; $display("FAIL retrig_level c%0d: got %b expected %b", c, level_a, exp_lv[c]);
            end
            n_checks++;
            if (busy_a !== exp_bz[c]) begin
                n_fail++; $display("FAIL retrig_busy c%0d: got %b expected %b", c, busy_a, exp_bz[c]);
            end
            n_checks++;
            if (pend_a !== 4'd0) begin
                n_fail++; $display("FAIL retrig_pend c%0d: got %0d expected 0", c, pend_a);
            end
        end
        tick_a = 1'b0;
        retrig_mode = 1'b0;
    endtask

    task automatic test_queue();
        logic [15:0] exp_lv = 16'h0666;
        logic [15:0] exp_bz = 16'h1FFE;
        int exp_p[15] = '{0, 0, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        hold_len = 8'd2; retrig_mode = 1'b0;
        tick_a = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            tick_a = (c <= 2);
            n_checks++;
            if (level_a !== exp_lv[c]) begin
                n_fail++; $display("FAIL queue_level c%0d: got %b expected %b", c, level_a, exp_lv[c]);
            end
            n_checks++;
            if (busy_a !== exp_bz[c]) begin
                n_fail++; $display("FAIL queue_busy c%0d: got %b expected %b", c, busy_a, exp_bz[c]);
            end
            n_checks++;
            if (pend_a !== 4'(exp_p[c])) begin
                n_fail++; $display("FAIL queue_pend c%0d: got %0d expected %0d", c, pend_a, exp_p[c]);
            end
        end
    endtask

    task automatic test_overflow();
        hold_len = 8'd20; retrig_mode = 1'b0;
        tick_b = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            tick_b  = (c <= 5) || (c == 7) || (c == 22);
            ovf_clr = (c >= 6) && (c <= 8);
            if (c == 6) begin
                n_checks++;
                if (pend_b !== 2'd3) begin
                    n_fail++; $display("FAIL ovf_pend_sat: got %0d expected 3", pend_b);
                end
                n_checks++;
                if (ovf_b !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_b);
                end
            end
            if (c == 7 || c == 9) begin
                n_checks++;
                if (ovf_b !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_clear c%0d: got %b expected 0", c, ovf_b);
                end
                n_checks++;
                if (pend_b !== 2'd3) begin
                    n_fail++; $display("FAIL ovf_pend_hold c%0d: got %0d expected 3", c, pend_b);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (ovf_b !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_b);
                end
            end
            if (c == 20 || c == 21) begin
                n_checks++;
                if (level_b !== (c == 20)) begin
                    n_fail++; $display("FAIL ovf_level_end c%0d: got %b expected %b", c, level_b, (c == 20));
                end
            end
            if (c == 23) begin
                n_checks++;
                if ({level_b, pend_b, ovf_b} !== 4'b1110) begin
                    n_fail++; $display("FAIL ovf_consume_and_queue: got %b expected 1110", {level_b, pend_b, ovf_b});
                end
            end
        end
        tick_b  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_lv = 16'h001E;
        hold_len = 8'd2; retrig_mode = 1'b0;
        tick_c = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            tick_c = 1'b0;
            n_checks++;
            if (level_c !== exp_lv[c]) begin
                n_fail++; $display("FAIL b2b_level c%0d: got %b expected %b", c, level_c, exp_lv[c]);
            end
            n_checks++;
            if (busy_c !== exp_lv[c]) begin
                n_fail++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy_c, exp_lv[c]);
            end
            if (c == 1) tick_c = 1'b1;
            if (c == 2) begin
                n_checks++;
                if (pend_c !== 4'd1) begin
                    n_fail++; $display("FAIL b2b_pend: got %0d expected 1", pend_c);
                end
            end
        end
        tick_c = 1'b0;
    endtask

    task automatic test_async_reset();
        hold_len = 8'd10; retrig_mode = 1'b0;
        tick_a = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            tick_a = (c <= 2);
        end
        tick_a = 1'b0;
        n_checks++;
        if ({level_a, pend_a} !== 5'b10010) begin
            n_fail++; $display("FAIL arst_pre: got %b expected 10010", {level_a, pend_a});
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({level_a, busy_a, pend_a} !== 6'd0) begin
            n_fail++; $display("FAIL arst_immediate: got %b expected 0", {level_a, busy_a, pend_a});
        end
        n_checks++;
        if ({level_b, busy_b, pend_b, ovf_b} !== 5'd0) begin
            n_fail++; $display("FAIL arst_b: got %b expected 0", {level_b, busy_b, pend_b, ovf_b});
        end
        #2 reset = 1'b1;
        step();
        step();
        hold_len = 8'd3;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        n_checks++;
        if (level_a !== 1'b1) begin
            n_fail++; $display("FAIL arst_restart_level: got %b expected 1", level_a);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_tick();
        test_zero_hold();
        test_retrigger();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
